// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin two-requester arbiter for a single-port image ROM
// Optional burst lock enabled by defining ROM_ARB_LOCK_EN.
module rom_read_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 24,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              lock0,
    output logic              gnt0,
    output logic [DATA_W-1:0] data0,
    output logic              valid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              lock1,
    output logic              gnt1,
    output logic [DATA_W-1:0] data1,
    output logic              valid1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

`ifdef ROM_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic               last_gnt_q, last_gnt_d;
    logic               granted_q, granted_d;
    logic [ROM_LAT-1:0] pv_q, pv_d;
    logic [ROM_LAT-1:0] po_q, po_d;
    logic [DATA_W-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic               valid0_q, valid0_d, valid1_q, valid1_d;
    logic               hold0, hold1;
    logic               ret_v, ret_o;

    // A lock only extends a grant that the same requester won in the previous cycle.
    assign hold0 = LockEn && granted_q && !last_gnt_q && lock0 && req0;
    assign hold1 = LockEn && granted_q &&  last_gnt_q && lock1 && req1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (hold0) begin
                gnt0 = 1'b1;
            end else if (hold1) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                gnt0 = last_gnt_q;
                gnt1 = !last_gnt_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        rom_addr = '0;
        if (gnt0) begin
            rom_addr = addr0;
        end else if (gnt1) begin
            rom_addr = addr1;
        end
    end

    assign last_gnt_d = gnt1 ? 1'b1 : (gnt0 ? 1'b0 : last_gnt_q);
    assign granted_d  = gnt0 | gnt1;

    // Stage 0 is written every cycle; the last stage lines up with rom_data.
    always_comb begin
        pv_d    = pv_q;
        po_d    = po_q;
        pv_d[0] = gnt0 | gnt1;
        po_d[0] = gnt1;
        for (int i = 1; i < ROM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            po_d[i] = po_q[i-1];
        end
    end

    assign ret_v = pv_q[ROM_LAT-1];
    assign ret_o = po_q[ROM_LAT-1];

    always_comb begin
        valid0_d = ret_v && !ret_o;
        valid1_d = ret_v &&  ret_o;
        data0_d  = valid0_d ? rom_data : data0_q;
        data1_d  = valid1_d ? rom_data : data1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            granted_q  <= 1'b0;
            pv_q       <= '0;
            po_q       <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            granted_q  <= granted_d;
            pv_q       <= pv_d;
            po_q       <= po_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
        end
    end

    assign data0  = data0_q;
    assign data1  = data1_q;
    assign valid0 = valid0_q;
    assign valid1 = valid1_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - scoreboard bench for rom_read_arbiter at ROM_LAT 1 and 3
module tb_rom_read_arbiter;

`ifdef ROM_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        bit          own;
        logic [23:0] data;
        int          due;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, lock0, lock1;
    logic [19:0] addr0, addr1;

    logic        g0_w [2];
    logic        g1_w [2];
    logic        v0_w [2];
    logic        v1_w [2];
    logic [23:0] d0_w [2];
    logic [23:0] d1_w [2];
    logic [23:0] rd_w [2];
    logic [19:0] ra_w [2];

    logic [19:0] rp1_q;
    logic [19:0] rp3_q [3];

    ent_t        sbq [2][$];
    logic [23:0] ed0 [2];
    logic [23:0] ed1 [2];
    bit          last_m;
    bit          gprev_m;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [19:0] a);
        if (a == 20'h00010) return 24'hABCDEF;
        return {a[11:0], ~a[11:0]} ^ 24'h5A5A00;
    endfunction

    // Image ROM models: one address register per latency cycle.
    always @(posedge clk) begin
        rp1_q    <= ra_w[0];
        rp3_q[0] <= ra_w[1];
        rp3_q[1] <= rp3_q[0];
        rp3_q[2] <= rp3_q[1];
    end
    assign rd_w[0] = rom_word(rp1_q);
    assign rd_w[1] = rom_word(rp3_q[2]);

    rom_read_arbiter #(.ADDR_W(20), .DATA_W(24), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(g0_w[0]), .data0(d0_w[0]), .valid0(v0_w[0]),
        .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(g1_w[0]), .data1(d1_w[0]), .valid1(v1_w[0]),
        .rom_addr(ra_w[0]), .rom_data(rd_w[0])
    );

    rom_read_arbiter #(.ADDR_W(20), .DATA_W(24), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .lock0(lock0), .gnt0(g0_w[1]), .data0(d0_w[1]), .valid0(v0_w[1]),
        .req1(req1), .addr1(addr1), .lock1(lock1), .gnt1(g1_w[1]), .data1(d1_w[1]), .valid1(v1_w[1]),
        .rom_addr(ra_w[1]), .rom_data(rd_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit          eg0, eg1, ev0, ev1;
        logic [19:0] ea;
        ent_t        e;
        @(negedge clk);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                sbq[k].delete();
                ed0[k] = '0;
                ed1[k] = '0;
            end
            last_m  = 1'b1;
            gprev_m = 1'b0;
        end
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            if (LOCK && gprev_m && !last_m && lock0 && req0)     eg0 = 1'b1;
            else if (LOCK && gprev_m && last_m && lock1 && req1) eg1 = 1'b1;
            else if (req0 && req1) begin
                if (last_m) eg0 = 1'b1;
                else        eg1 = 1'b1;
            end
            else if (req0) eg0 = 1'b1;
            else if (req1) eg1 = 1'b1;
        end
        ea = eg0 ? addr0 : (eg1 ? addr1 : 20'h0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("gnt0[%0d]", k), 32'(g0_w[k]), 32'(eg0));
            chk($sformatf("gnt1[%0d]", k), 32'(g1_w[k]), 32'(eg1));
            chk($sformatf("rom_addr[%0d]", k), 32'(ra_w[k]), 32'(ea));
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
                e = sbq[k].pop_front();
                if (e.own) begin ev1 = 1'b1; ed1[k] = e.data; end
                else       begin ev0 = 1'b1; ed0[k] = e.data; end
            end
            chk($sformatf("valid0[%0d]", k), 32'(v0_w[k]), 32'(ev0));
            chk($sformatf("valid1[%0d]", k), 32'(v1_w[k]), 32'(ev1));
            chk($sformatf("data0[%0d]", k), 32'(d0_w[k]), 32'(ed0[k]));
            chk($sformatf("data1[%0d]", k), 32'(d1_w[k]), 32'(ed1[k]));
        end
        if (eg0 || eg1) begin
            for (int k = 0; k < 2; k++) begin
                e.own  = eg1;
                e.data = rom_word(ea);
                e.due  = cyc + (k == 0 ? 1 : 3) + 1;
                sbq[k].push_back(e);
            end
            last_m  = eg1;
            gprev_m = 1'b1;
        end else begin
            gprev_m = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = '0; addr1 = '0;
        step();
        step();
        rst = 1'b0;

        req0 = 1'b1; addr0 = 20'h00010;
        step();
        req0 = 1'b0; addr0 = '0;
        repeat (4) step();

        for (int i = 0; i < 6; i++) begin
            req0 = 1'b1; addr0 = 20'h00100 + 20'(i);
            req1 = 1'b1; addr1 = 20'h00200 + 20'(i);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();

        for (int i = 5; i <= 8; i++) begin
            req1 = 1'b1; addr1 = 20'(i);
            step();
        end
        req1 = 1'b0;
        repeat (5) step();

        req0 = 1'b1; addr0 = 20'h00333;
        req1 = 1'b1; addr1 = 20'h00444;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_valid0", 32'(v0_w[k]), 32'd0);
            chk("async_valid1", 32'(v1_w[k]), 32'd0);
            chk("async_data0", 32'(d0_w[k]), 32'd0);
            chk("async_data1", 32'(d1_w[k]), 32'd0);
            chk("async_gnt", 32'({g0_w[k], g1_w[k]}), 32'd0);
        end
        step();
        step();
        rst = 1'b0;
        addr0 = 20'h00555; addr1 = 20'h00666;
        #1 chk("post_reset_gnt0", 32'(g0_w[0]), 32'd1);
        step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) step();

        req1 = 1'b1; addr1 = 20'h00700;
        step();
        for (int i = 0; i < 5; i++) begin
            req0 = 1'b1; lock0 = 1'b1; addr0 = 20'h00800 + 20'(i);
            addr1 = 20'h00900 + 20'(i);
            step();
        end
        lock0 = 1'b0;
        addr0 = 20'h00810; addr1 = 20'h00910;
        step();
        step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (5) step();

        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares one synchronous image ROM (single read port, fixed read latency) between two pixel requesters, e.g. the title-screen drawer and the menu overlay drawer.
- Arbitrates round-robin, one read per cycle.
- Drives the ROM address and routes each returned word to its requester, with a registered data and valid pair.
- Sits between the draw modules and the ROM inside the VGA pixel path.

Parameters:
- ADDR_W, 20, width of the ROM address and requester addresses.
- DATA_W, 24, ROM word width (RGB888).
- ROM_LAT, 1, ROM read latency in cycles from address sampled to rom_data valid; legal range 1..4.

Ports:
- clk  input  1  system pixel clock.
- rst  input  1  asynchronous reset, active-high.
- req0  input  1  requester 0 read request.
- addr0  input  ADDR_W  requester 0 address; must be valid while req0 is high.
- lock0  input  1  requester 0 burst lock; used only when the feature is enabled.
- gnt0  output  1  requester 0 granted this cycle (combinational).
- data0  output  DATA_W  requester 0 returned word (registered).
- valid0  output  1  data0 valid pulse (registered).
- req1, addr1, lock1, gnt1, data1, valid1: same as the requester 0 ports, for requester 1.
- rom_addr  output  ADDR_W  address to the ROM (combinational mux).
- rom_data  input  DATA_W  ROM read data.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - pipeline owner/valid stages clear;
  - data0 and data1 go to 0;
  - valid0 and valid1 go to 0;
  - last_gnt goes to 1, so requester 0 wins the first contention.
- gnt0, gnt1 and rom_addr are combinational. During reset gnt is forced to 0 and rom_addr is 0.
- Arbitration, evaluated each cycle:
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_gnt.
  - Neither high: no grant; rom_addr = 0.
- gnt0 and gnt1 are never both high.
- rom_addr equals the granted requester's addr in the same cycle.
- On every clk edge with a grant, last_gnt updates to the granted index. With no grant, last_gnt holds.
- Return pipeline:
  - A shift register of depth ROM_LAT carries {valid, owner}.
  - A stage entry is written for every cycle, with valid = (grant issued).
- Latency:
  - A grant in cycle t means rom_data is valid in cycle t+ROM_LAT.
  - At the clock edge ending cycle t+ROM_LAT, data<owner> is loaded with rom_data and valid<owner> is set for one cycle.
  - Total latency is ROM_LAT+1 cycles from grant to valid.
- dataN holds its last value when validN is low. The other requester's data register is not touched.
- Back-to-back grants give back-to-back valid pulses in grant order. Throughput is 1 word per cycle.
- A requester dropping req before a grant loses nothing. Requests are not queued; req must be held until gnt is seen.
- Reset mid-operation: all in-flight reads are discarded and no valid pulse is issued for them after reset.

Optional Feature:
- Macro: ROM_ARB_LOCK_EN.
- Enabled:
  - If requester n was granted in the previous cycle and lock_n and req_n are both high now, requester n is granted again regardless of the other request.
  - This lets a draw module fetch a full line burst uninterrupted.
  - Lock ends when lock_n or req_n drops. Normal round-robin resumes, with last_gnt = n.
- Disabled: lock0 and lock1 are ignored (ports remain); pure round-robin.

Test Plan:
- Reset release, ROM_LAT=1, req0=1 with addr0=0x00010 for one cycle, ROM model returns 0xABCDEF → gnt0=1 in that cycle, rom_addr=0x00010, valid0=1 with data0=0xABCDEF exactly 2 cycles after grant, valid1 stays 0.
- req0 and req1 both held high for 6 cycles with distinct addresses → grants alternate 0,1,0,1,0,1 (requester 0 first); valid pulses alternate with matching data; never gnt0 and gnt1 both high.
- ROM_LAT=3, req1 only, 4 consecutive cycles with addresses 5..8 → valid1 high for 4 consecutive cycles starting 4 cycles after the first grant, data1 = ROM[5..8] in order.
- Reset asserted asynchronously (mid-cycle) with 2 reads in flight → valid0, valid1, data0 and data1 are 0 immediately; no valid pulse after reset deasserts; the next contention is granted to requester 0.
- ROM_ARB_LOCK_EN defined, req0 with lock0 high for 5 cycles while req1 is high → gnt0 for all 5 cycles; gnt1 in the cycle after lock0 drops. Without the macro, the same stimulus alternates grants.
- Idle (no req) for 10 cycles → rom_addr=0, no grants, data registers hold their last values, valid stays 0.
